mem_access_unit: RTL and testbench

Load/store front end sitting directly upstream of the word-indexed data memory: takes byte-addressed load/store requests from the execute stage and drives the memory's `MemRead`/`MemWrite`/`ALUOut`/`reg2data` ports. Converts byte addresses to word indices, performs byte/halfword stores as a two-cycle read-modify-write, and returns sign- or zero-extended load data. Flags misaligned and out-of-range accesses so that no illegal memory access is issued.

---
 rtl/mem_access_pkg.sv | 16 +
 rtl/mem_access_unit_byte_lane_unit.sv | 63 ++++++
 rtl/mem_access_unit.sv | 135 +++++++++++++
 tb/tb_mem_access_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared encodings for the load/store front end: access sizes, FSM states,
// and the default data-memory depth.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int DEF_MEM_WORDS = 200;

    typedef enum logic {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } state_t;

endpackage

// File: rtl/mem_access_unit_byte_lane_unit.sv
// Combinational lane logic shared by the load path and the store-merge path:
// extracts/extends a byte, half or word from word_in, and produces word_in
// with the addressed lane(s) replaced by the low bits of wdata.
module byte_lane_unit
    import mem_access_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        is_unsigned,
    input  logic [31:0] word_in,
    input  logic [31:0] wdata,
    output logic [31:0] load_ext,
    output logic [31:0] merged
);

    logic [7:0]  word_bytes [4];
    logic [3:0]  byte_we;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign word_bytes[gi] = word_in[8*gi +: 8];
            // Byte stores replicate wdata[7:0], half stores wdata[15:0],
            // so each lane only needs to know which source byte it takes.
            if (gi % 2 == 0) begin : g_even
                assign merged[8*gi +: 8] = !byte_we[gi] ? word_in[8*gi +: 8] :
                                           (size[1] ? wdata[8*gi +: 8] : wdata[7:0]);
            end else begin : g_odd
                assign merged[8*gi +: 8] = !byte_we[gi] ? word_in[8*gi +: 8] :
                                           (size[1] ? wdata[8*gi +: 8] :
                                            (size == SZ_HALF ? wdata[15:8] : wdata[7:0]));
            end
        end
    endgenerate

    // Lane write enables for the merge path (size 11 behaves as a word).
    always_comb begin
        byte_we = 4'b0000;
        if (size == SZ_BYTE) begin
            byte_we[lane] = 1'b1;
        end else if (size == SZ_HALF) begin
            byte_we = lane[1] ? 4'b1100 : 4'b0011;
        end else begin
            byte_we = 4'b1111;
        end
    end

    // Load extract and sign/zero extension.
    always_comb begin
        byte_sel = word_bytes[lane];
        half_sel = lane[1] ? word_in[31:16] : word_in[15:0];
        if (size == SZ_BYTE) begin
            load_ext = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
        end else if (size == SZ_HALF) begin
            load_ext = {{16{~is_unsigned & half_sel[15]}}, half_sel};
        end else begin
            load_ext = word_in;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for a word-indexed data memory. Loads complete in one
// cycle; sub-word stores read the word, then write the merged word in a
// second (MERGE) cycle during which new requests are stalled.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_WORDS = DEF_MEM_WORDS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        misalign,
    output logic        oob,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] ALUOut,
    output logic [31:0] reg2data,
    input  logic [31:0] memout
);

    localparam logic [31:0] MEM_WORDS_L = 32'(MEM_WORDS);

    state_t      state_reg, state_next;
    logic [31:0] hold_reg;
    logic [1:0]  lane_reg;
    logic [1:0]  size_reg;
    logic [31:0] wdata_reg;
    logic [29:0] idx_reg;
    logic [31:0] load_data_reg;
    logic        load_valid_reg, misalign_reg, oob_reg;

    logic        accept, is_read, is_write, sz_word;
    logic        misalign_c, oob_c, access_ok;
    logic        ld_go, st_word_go, st_sub_go;
    logic [1:0]  lu_size, lu_lane;
    logic [31:0] lu_word, lu_wdata, lu_load, lu_merged;

    assign accept     = req_valid && (state_reg == IDLE) && !rst;
    assign is_read    = req_read;
    assign is_write   = req_write && !req_read;
    assign sz_word    = (req_size == SZ_WORD) || (req_size == 2'b11);
    assign misalign_c = ((req_size == SZ_HALF) && req_addr[0]) ||
                        (sz_word && (req_addr[1:0] != 2'b00));
    assign oob_c      = {2'b00, req_addr[31:2]} >= MEM_WORDS_L;
    assign access_ok  = accept && !misalign_c && !oob_c;
    assign ld_go      = access_ok && is_read;
    assign st_word_go = access_ok && is_write && sz_word;
    assign st_sub_go  = access_ok && is_write && !sz_word;

    // In MERGE the lane unit works on the captured store; otherwise on the live request.
    assign lu_size  = (state_reg == MERGE) ? size_reg  : req_size;
    assign lu_lane  = (state_reg == MERGE) ? lane_reg  : req_addr[1:0];
    assign lu_word  = (state_reg == MERGE) ? hold_reg  : memout;
    assign lu_wdata = (state_reg == MERGE) ? wdata_reg : req_wdata;

    byte_lane_unit u_lane (
        .size        (lu_size),
        .lane        (lu_lane),
        .is_unsigned (req_unsigned),
        .word_in     (lu_word),
        .wdata       (lu_wdata),
        .load_ext    (lu_load),
        .merged      (lu_merged)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: enter MERGE only for a legal sub-word store; leave unconditionally.
    always_comb begin
        state_next = IDLE;
        if (state_reg == IDLE && st_sub_go) begin
            state_next = MERGE;
        end
    end

    // Memory-side strobes and stall; strobes are held low during reset.
    always_comb begin
        stall    = (state_reg == MERGE);
        MemRead  = !rst && (ld_go || st_sub_go);
        MemWrite = !rst && (st_word_go || state_reg == MERGE);
        ALUOut   = (state_reg == MERGE) ? {2'b00, idx_reg} : {2'b00, req_addr[31:2]};
        reg2data = (state_reg == MERGE) ? lu_merged : req_wdata;
    end

    // Capture registers for the read-modify-write and registered load/error results.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_reg       <= '0;
            lane_reg       <= '0;
            size_reg       <= '0;
            wdata_reg      <= '0;
            idx_reg        <= '0;
            load_data_reg  <= '0;
            load_valid_reg <= 1'b0;
            misalign_reg   <= 1'b0;
            oob_reg        <= 1'b0;
        end else begin
            load_valid_reg <= ld_go;
            misalign_reg   <= accept && misalign_c;
            oob_reg        <= accept && oob_c;
            if (ld_go) begin
                load_data_reg <= lu_load;
            end
            if (st_sub_go) begin
                hold_reg  <= memout;
                lane_reg  <= req_addr[1:0];
                size_reg  <= req_size;
                wdata_reg <= req_wdata;
                idx_reg   <= req_addr[31:2];
            end
        end
    end

    assign load_data  = load_data_reg;
    assign load_valid = load_valid_reg;
    assign misalign   = misalign_reg;
    assign oob        = oob_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: a behavioural 200-word memory, directed
// stimulus with hand-computed expectations, and a scoreboard monitor that
// checks every load_valid/misalign/oob pulse against a queue of expected results.
module tb_mem_access_unit;
    import mem_access_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_read, req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        stall, load_valid, misalign, oob, MemRead, MemWrite;
    logic [31:0] load_data, ALUOut, reg2data, memout;

    logic [31:0] mem [200];

    typedef struct {
        logic        lv;
        logic        mis;
        logic        oob;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_WORDS(200)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_read     (req_read),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .stall        (stall),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .misalign     (misalign),
        .oob          (oob),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .ALUOut       (ALUOut),
        .reg2data     (reg2data),
        .memout       (memout)
    );

    assign memout = (ALUOut < 32'd200) ? mem[ALUOut[7:0]] : 32'h0;

    always @(posedge clk) begin
        if (MemWrite && ALUOut < 32'd200) begin
            mem[ALUOut[7:0]] <= reg2data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: %08h (t=%0t)", name, act, $time);
        end
    endtask

    function automatic void push_exp(input logic lv, input logic mis, input logic ob,
                                     input logic [31:0] d);
        exp_t e;
        e.lv = lv; e.mis = mis; e.oob = ob; e.data = d;
        exp_q.push_back(e);
    endfunction

    // Drive one request at the falling edge; combinational outputs settle by +2.
    task automatic issue(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1; req_read = rd; req_write = wr; req_size = sz;
        req_unsigned = uns; req_addr = a; req_wdata = wd;
        #2;
    endtask

    task automatic nop();
        @(negedge clk);
        req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
        #2;
    endtask

    task automatic store_word(input logic [31:0] a, input logic [31:0] d);
        issue(1'b0, 1'b1, SZ_WORD, 1'b0, a, d);
        chk("sw_memwrite", {31'b0, MemWrite}, 32'd1);
    endtask

    task automatic load(input logic [1:0] sz, input logic uns, input logic [31:0] a,
                        input logic [31:0] exp, input string name);
        issue(1'b1, 1'b0, sz, uns, a, 32'h0);
        chk({name, "_memread"}, {31'b0, MemRead}, 32'd1);
        push_exp(1'b1, 1'b0, 1'b0, exp);
    endtask

    // Scoreboard monitor: one pop per output pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (load_valid || misalign || oob) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", {29'b0, load_valid, misalign, oob}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_flags", {29'b0, load_valid, misalign, oob},
                        {29'b0, e.lv, e.mis, e.oob});
                    if (e.lv) chk("sb_load_data", load_data, e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
        req_size = SZ_WORD; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        // Reset state, with a load request presented: strobes must stay low.
        req_valid = 1'b1; req_read = 1'b1; req_addr = 32'h10;
        #2;
        chk("rst_memread", {31'b0, MemRead}, 32'd0);
        chk("rst_outputs", {28'b0, stall, load_valid, misalign, oob}, 32'd0);
        chk("rst_load_data", load_data, 32'h0);
        @(negedge clk);
        rst = 1'b0; req_valid = 1'b0; req_read = 1'b0;

        // Word round trip.
        store_word(32'h10, 32'hDEADBEEF);
        chk("sw_aluout", ALUOut, 32'd4);
        chk("sw_reg2data", reg2data, 32'hDEADBEEF);
        nop();
        chk("sw_mem4", mem[4], 32'hDEADBEEF);
        load(SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, "lw10");
        chk("lw_aluout", ALUOut, 32'd4);

        // Signed/unsigned sub-word loads.
        store_word(32'h10, 32'h80FF7F01);
        load(SZ_BYTE, 1'b0, 32'h13, 32'hFFFFFF80, "lb13");
        load(SZ_BYTE, 1'b1, 32'h13, 32'h00000080, "lbu13");
        load(SZ_BYTE, 1'b0, 32'h11, 32'h0000007F, "lb11");
        load(SZ_HALF, 1'b1, 32'h12, 32'h000080FF, "lhu12");
        load(SZ_HALF, 1'b0, 32'h10, 32'h00007F01, "lh10");

        // Byte store RMW with a load held during the stall.
        store_word(32'h10, 32'h11223344);
        issue(1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h12, 32'h000000AA);
        chk("sb_accept", {29'b0, MemRead, MemWrite, stall}, 32'b100);
        issue(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0);
        chk("sb_merge", {29'b0, MemRead, MemWrite, stall}, 32'b011);
        chk("sb_merge_aluout", ALUOut, 32'd4);
        chk("sb_merge_data", reg2data, 32'h11AA3344);
        @(negedge clk);
        #2;
        chk("held_accept", {30'b0, MemRead, stall}, 32'b10);
        push_exp(1'b1, 1'b0, 1'b0, 32'h11AA3344);
        chk("sb_mem4", mem[4], 32'h11AA3344);
        nop();

        // Half store, signed half load, then a lane-0 byte store.
        store_word(32'h10, 32'h11223344);
        issue(1'b0, 1'b1, SZ_HALF, 1'b0, 32'h12, 32'h0000BEEF);
        nop();
        chk("sh_stall", {31'b0, stall}, 32'd1);
        nop();
        chk("sh_mem4", mem[4], 32'hBEEF3344);
        load(SZ_HALF, 1'b0, 32'h12, 32'hFFFFBEEF, "lh12");
        issue(1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h10, 32'hFFFFFF55);
        nop();
        nop();
        chk("sb0_mem4", mem[4], 32'hBEEF3355);

        // Rejected accesses and the top legal index.
        issue(1'b1, 1'b0, SZ_WORD, 1'b0, 32'h06, 32'h0);
        chk("lw06_memread", {31'b0, MemRead}, 32'd0);
        push_exp(1'b0, 1'b1, 1'b0, 32'h0);
        issue(1'b0, 1'b1, SZ_WORD, 1'b0, 32'h320, 32'h12345678);
        chk("sw320_memwrite", {31'b0, MemWrite}, 32'd0);
        push_exp(1'b0, 1'b0, 1'b1, 32'h0);
        issue(1'b1, 1'b0, SZ_HALF, 1'b0, 32'h321, 32'h0);
        chk("lh321_memread", {31'b0, MemRead}, 32'd0);
        push_exp(1'b0, 1'b1, 1'b1, 32'h0);
        store_word(32'h31C, 32'hCAFEF00D);
        load(SZ_WORD, 1'b0, 32'h31C, 32'hCAFEF00D, "lw31c");

        // Reset during MERGE abandons the write.
        store_word(32'h14, 32'h12345678);
        issue(1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h14, 32'h00000099);
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'b0; rst = 1'b1;
        #2;
        chk("rstm_strobes", {30'b0, MemRead, MemWrite}, 32'd0);
        @(negedge clk);
        #2;
        chk("rstm_outputs", {28'b0, stall, load_valid, misalign, oob}, 32'd0);
        chk("rstm_load_data", load_data, 32'h0);
        rst = 1'b0;
        nop();
        chk("rstm_mem5", mem[5], 32'h12345678);

        repeat (3) nop();
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
